// File: rtl/f_event_monitor.sv
// Rising-edge event counter on a sampled function input, with a Req/Ack snapshot handshake.
// Define F_EVENT_MONITOR_SYNC_EN to insert a 2-flop synchronizer ahead of the sample flop.
module f_event_monitor (
    input  logic       Clock,
    input  logic       Reset_b,
    input  logic       F,
    input  logic       Clr,
    input  logic       Req,
    input  logic       Ack,
    output logic [7:0] Count,
    output logic       Valid,
    output logic       Overflow
);

    typedef enum logic {
        IDLE   = 1'b0,
        REPORT = 1'b1
    } state_t;

    state_t     state_reg;
    logic [7:0] run_reg;
    logic [7:0] count_reg;
    logic       valid_reg;
    logic       overflow_reg;
    logic       fs_reg;
    logic       fp_reg;
    logic       evt_reg;
    logic       f_in;
    logic       snap;

`ifdef F_EVENT_MONITOR_SYNC_EN
    logic [1:0] sync_reg;

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], F};
        end
    end

    assign f_in = sync_reg[1];
`else
    assign f_in = F;
`endif

    // Clr has priority, so a snapshot can only happen with Clr low.
    assign snap = (state_reg == IDLE) && Req && !Clr;

    always_ff @(posedge Clock) begin
        if (!Reset_b) begin
            state_reg    <= IDLE;
            valid_reg    <= 1'b0;
            count_reg    <= 8'h00;
            run_reg      <= 8'h00;
            overflow_reg <= 1'b0;
            fs_reg       <= 1'b0;
            fp_reg       <= 1'b0;
            evt_reg      <= 1'b0;
        end else begin
            fs_reg  <= f_in;
            fp_reg  <= fs_reg;
            // Registered edge flag: Run moves two edges after F is first sampled high.
            evt_reg <= fs_reg & ~fp_reg;

            if (Clr) begin
                run_reg      <= 8'h00;
                overflow_reg <= 1'b0;
            end else if (snap) begin
                count_reg <= run_reg;
                run_reg   <= {7'd0, evt_reg};
                if (!evt_reg) begin
                    overflow_reg <= 1'b0;
                end
            end else if (evt_reg) begin
                if (run_reg == 8'hFF) begin
                    overflow_reg <= 1'b1;
                end else begin
                    run_reg <= run_reg + 8'd1;
                end
            end

            if (!Clr) begin
                case (state_reg)
                    IDLE: begin
                        if (Req) begin
                            state_reg <= REPORT;
                            valid_reg <= 1'b1;
                        end
                    end
                    REPORT: begin
                        if (Ack) begin
                            state_reg <= IDLE;
                            valid_reg <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Count    = count_reg;
    assign Valid    = valid_reg;
    assign Overflow = overflow_reg;

endmodule
